grid_scan: RTL and testbench
============================

GRID_SCAN -- requirements
Module: grid_scan

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 833333, meaning clk cycles per frame tick (50 MHz / 60 Hz).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_updated  input  144  playfield; cell (x,y) at bit 18*x + y, x 0..7, y 0..17.
REQ-005 SHALL have port pix_ready  input  1  downstream sink accepts the current cell.
REQ-006 SHALL have port pix_valid  output  1  a cell is presented on pix_x, pix_y and pix_on.
REQ-007 SHALL have port pix_x  output  4  cell column.
REQ-008 SHALL have port pix_y  output  5  cell row.
REQ-009 SHALL have port pix_on  output  1  cell occupied.
REQ-010 SHALL have port draw_finish  output  1  one-cycle pulse at end of frame scan; feeds the game controller.
REQ-011 SHALL have port frame_overrun  output  1  sticky; a frame tick was dropped.

Function
REQ-012 SHALL run a free counter 0..FRAME_CYCLES-1, wrapping to 0; tick = (count == FRAME_CYCLES-1).
REQ-013 SHALL implement states IDLE, SCAN, DONE.
REQ-014 IDLE: on tick, SHALL copy data_updated into a 144-bit snapshot in the same cycle and enter SCAN.
REQ-015 SCAN SHALL present cells row-major, y outer 0..17 and x inner 0..7, starting at (0,0) the cycle after the tick.
REQ-016 pix_on SHALL equal snapshot bit 18*pix_x + pix_y; data_updated changes during SCAN SHALL NOT affect output.
REQ-017 Handshake: pix_valid SHALL stay 1 and pix_x, pix_y and pix_on SHALL stay stable until a cycle with pix_valid and pix_ready; the next cell follows in the next cycle.
REQ-018 When the last cell (7,17) is accepted, the block SHALL enter DONE; DONE SHALL drive draw_finish=1 and pix_valid=0 for exactly one cycle, then return to IDLE.
REQ-019 A tick arriving in SCAN or DONE SHALL be dropped, SHALL set frame_overrun=1, and SHALL leave the scan unaffected.
REQ-020 draw_finish SHALL never be high for two consecutive cycles, and SHALL never be high outside DONE.
REQ-021 With pix_ready held high, draw_finish SHALL occur exactly 145 cycles after the tick cycle; with the border feature, 201 cycles.

Reset
REQ-022 While rst=1, the block SHALL set state=IDLE, frame counter=0, pix_valid=0, pix_x=0, pix_y=0, pix_on=0, draw_finish=0, frame_overrun=0 and snapshot=0.
REQ-023 rst asserted mid-scan SHALL abort the frame with no draw_finish; the first tick after release SHALL occur FRAME_CYCLES cycles after the first cycle with rst=0.

Configuration
REQ-024 When macro GRID_SCAN_BORDER_EN is defined, the block SHALL scan 10x20 cells (x 0..9, y 0..19), keeping the same row-major order.
REQ-025 With GRID_SCAN_BORDER_EN, cells with x=0, x=9, y=0 or y=19 SHALL have pix_on=1; inner cell (x,y) SHALL take snapshot bit 18*(x-1) + (y-1); the scan SHALL end at (9,19).
REQ-026 Without GRID_SCAN_BORDER_EN, the block SHALL scan 8x18 cells per REQ-015, and no border logic SHALL be synthesized.

Verification
REQ-027 FRAME_CYCLES=400, pix_ready=1, data_updated=0 -> first tick at cycle 399; cells (0,0)..(7,17) at cycles 400..543, all pix_on=0; draw_finish only at cycle 544.
REQ-028 Bit 18*3+5 set (cell (3,5)), all other bits 0 -> pix_on=1 only at the cell with pix_x=3, pix_y=5.
REQ-029 pix_ready=0 for 10 cycles while cell (2,0) is presented -> pix_valid and cell stay constant for those 10 cycles; scan resumes at (3,0); draw_finish is delayed by 10 cycles.
REQ-030 Set data_updated bit 0 one cycle after the tick -> pix_on at (0,0) stays 0 (snapshot holds); the next frame shows 1.
REQ-031 FRAME_CYCLES=100, pix_ready=0 -> frame_overrun=1 after the second tick and stays 1 until rst.
REQ-032 Pulse rst at cell (4,9) -> pix_valid=0 on the next cycle, no draw_finish, next tick after FRAME_CYCLES cycles; with GRID_SCAN_BORDER_EN, cell (0,5)=1, cell (1,1) equals bit 0, and draw_finish follows 201 cycles after the tick.

Source files
------------

// File: rtl/grid_scan.sv
// rtl/grid_scan.sv - frame-paced playfield cell scanner with ready/valid output
// Optional 10x20 scan with a lit border when GRID_SCAN_BORDER_EN is defined.
`timescale 1ns/1ps
module grid_scan #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] data_updated,
  input  logic         pix_ready,
  output logic         pix_valid,
  output logic [3:0]   pix_x,
  output logic [4:0]   pix_y,
  output logic         pix_on,
  output logic         draw_finish,
  output logic         frame_overrun
);

  localparam int CW = $clog2(FRAME_CYCLES + 1);
`ifdef GRID_SCAN_BORDER_EN
  localparam logic [3:0] X_MAX = 4'd9;
  localparam logic [4:0] Y_MAX = 5'd19;
`else
  localparam logic [3:0] X_MAX = 4'd7;
  localparam logic [4:0] Y_MAX = 5'd17;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  count;
  logic           tick;
  logic [143:0]   snapshot;
  logic [3:0]     x_nxt;
  logic [4:0]     y_nxt;
  logic           load;
  logic           last;

  assign tick = (count == CW'(FRAME_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      state         <= IDLE;
      pix_x         <= '0;
      pix_y         <= '0;
      snapshot      <= '0;
      frame_overrun <= 1'b0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      state <= state_nxt;
      pix_x <= x_nxt;
      pix_y <= y_nxt;
      if (load)
        snapshot <= data_updated;
      // Ticks are only consumed in IDLE; any other tick is lost.
      if (tick && state != IDLE)
        frame_overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    x_nxt       = pix_x;
    y_nxt       = pix_y;
    load        = 1'b0;
    pix_valid   = 1'b0;
    draw_finish = 1'b0;
    last        = (pix_x == X_MAX) && (pix_y == Y_MAX);
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = SCAN;
          load      = 1'b1;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      SCAN: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          if (last) begin
            state_nxt = DONE;
            x_nxt     = '0;
            y_nxt     = '0;
          end else if (pix_x == X_MAX) begin
            x_nxt = '0;
            y_nxt = pix_y + 5'd1;
          end else begin
            x_nxt = pix_x + 4'd1;
          end
        end
      end
      DONE: begin
        draw_finish = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GRID_SCAN_BORDER_EN
  logic       on_border;
  logic [7:0] inner_idx;

  always_comb begin
    on_border = (pix_x == 4'd0) || (pix_x == X_MAX) || (pix_y == 5'd0) || (pix_y == Y_MAX);
    inner_idx = 8'd18 * (8'(pix_x) - 8'd1) + (8'(pix_y) - 8'd1);
    pix_on    = pix_valid && (on_border || ((inner_idx < 8'd144) && snapshot[inner_idx]));
  end
`else
  logic [7:0] cell_idx;

  always_comb begin
    cell_idx = 8'd18 * 8'(pix_x) + 8'(pix_y);
    pix_on   = pix_valid && snapshot[cell_idx];
  end
`endif

endmodule

// File: tb/tb_grid_scan.sv
// tb/tb_grid_scan.sv - randomized self-checking bench for grid_scan against a queue-based frame model
`timescale 1ns/1ps
module tb_grid_scan;

  localparam int FC = 400;
`ifdef GRID_SCAN_BORDER_EN
  localparam int XN = 10, YN = 20;
  localparam int FIN0 = 600, FIN_STALL = 610, ONES0 = 56, ONES1 = 57;
  localparam int TX = 4, TY = 6, PX = 1, PY = 1;
`else
  localparam int XN = 8, YN = 18;
  localparam int FIN0 = 544, FIN_STALL = 554, ONES0 = 0, ONES1 = 1;
  localparam int TX = 3, TY = 5, PX = 0, PY = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [143:0] data_updated = '0;
  logic         pix_ready = 1'b1;
  logic         pix_valid;
  logic [3:0]   pix_x;
  logic [4:0]   pix_y;
  logic         pix_on;
  logic         draw_finish;
  logic         frame_overrun;

  grid_scan #(.FRAME_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .data_updated(data_updated), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on),
    .draw_finish(draw_finish), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 scanning, 2 finish cycle; expected cells are queued at the tick.
  int m_cnt = 0;
  int m_phase = 0;
  bit m_ovr = 0;
  bit m_after_rst = 1;
  bit m_tick;
  int qx[$];
  int qy[$];
  bit qon[$];

  int rel = 0;
  int first_valid_rel = -1;
  int finish_rel = -1;
  int frames = 0;
  int ones = 0;
  int target_on = -1;
  int probe_on[2] = '{-1, -1};

  task automatic build_frame(input logic [143:0] du);
    bit on;
    for (int y = 0; y < YN; y++)
      for (int x = 0; x < XN; x++) begin
`ifdef GRID_SCAN_BORDER_EN
        if (x == 0 || x == XN-1 || y == 0 || y == YN-1) on = 1'b1;
        else on = du[18*(x-1) + (y-1)];
`else
        on = du[18*x + y];
`endif
        qx.push_back(x);
        qy.push_back(y);
        qon.push_back(on);
      end
  endtask

  always @(negedge clk) begin
    if (m_phase == 1 && qx.size() > 0) begin
      chk("valid_scan", pix_valid, 1);
      chk("pix_x", pix_x, qx[0]);
      chk("pix_y", pix_y, qy[0]);
      chk("pix_on", pix_on, qon[0]);
      chk("finish_scan", draw_finish, 0);
    end else begin
      chk("valid_idle", pix_valid, 0);
      chk("draw_finish", draw_finish, (m_phase == 2) ? 1 : 0);
    end
    chk("frame_overrun", frame_overrun, m_ovr);
    if (m_after_rst) begin
      chk("rst_x", pix_x, 0);
      chk("rst_y", pix_y, 0);
      chk("rst_on", pix_on, 0);
    end

    if (pix_valid && first_valid_rel < 0) first_valid_rel = rel;
    if (pix_valid && pix_ready) begin
      if (frames == 0 && pix_on) ones++;
      if (frames == 0 && pix_x == TX && pix_y == TY) target_on = pix_on;
      if (frames < 2 && pix_x == PX && pix_y == PY) probe_on[frames] = pix_on;
    end
    if (draw_finish) begin
      if (finish_rel < 0) finish_rel = rel;
      frames++;
    end

    if (rst) begin
      m_cnt = 0; m_phase = 0; m_ovr = 0; m_after_rst = 1;
      qx.delete(); qy.delete(); qon.delete();
      rel = 0; first_valid_rel = -1; finish_rel = -1; frames = 0; ones = 0;
      target_on = -1; probe_on[0] = -1; probe_on[1] = -1;
    end else begin
      m_after_rst = 0;
      rel++;
      m_tick = (m_cnt == FC-1);
      m_cnt = m_tick ? 0 : m_cnt + 1;
      case (m_phase)
        0: if (m_tick) begin build_frame(data_updated); m_phase = 1; end
        1: begin
          if (m_tick) m_ovr = 1;
          if (pix_ready) begin
            void'(qx.pop_front()); void'(qy.pop_front()); void'(qon.pop_front());
            if (qx.size() == 0) m_phase = 2;
          end
        end
        default: begin
          if (m_tick) m_ovr = 1;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (frames < n && k < budget) begin cyc(1); k++; end
    if (frames < n) chk({name, "_timeout"}, frames, n);
  endtask

  task automatic wait_cell(input int x, input int y, input int budget);
    int k = 0;
    while (!(pix_valid && pix_x == x && pix_y == y) && k < budget) begin cyc(1); k++; end
    chk("wait_cell_found", (pix_valid && pix_x == x && pix_y == y) ? 1 : 0, 1);
  endtask

  function automatic logic [143:0] rand144();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    return t[143:0];
  endfunction

  initial begin
    // Empty field, ready held high: first cell and finish timing.
    data_updated = '0; pix_ready = 1'b1;
    do_reset();
    wait_frames(1, 1000, "empty");
    chk("first_valid_cycle", first_valid_rel, 400);
    chk("finish_cycle", finish_rel, FIN0);
    chk("ones_empty", ones, ONES0);

    // Single occupied cell (3,5).
    data_updated = '0; data_updated[18*3 + 5] = 1'b1;
    do_reset();
    wait_frames(1, 1000, "single");
    chk("ones_single", ones, ONES1);
    chk("target_cell_on", target_on, 1);

    // Ten-cycle stall on cell (2,0).
    data_updated = rand144();
    do_reset();
    wait_cell(2, 0, 600);
    pix_ready = 1'b0;
    cyc(10);
    pix_ready = 1'b1;
    wait_frames(1, 1000, "stall");
    chk("finish_stalled", finish_rel, FIN_STALL);

    // Input change right after the tick must not reach this frame.
    data_updated = '0;
    do_reset();
    cyc(400);
    data_updated[0] = 1'b1;
    wait_frames(2, 1500, "snapshot");
    chk("snapshot_frame0", probe_on[0], 0);
    chk("snapshot_frame1", probe_on[1], 1);

    // Sink never ready: second tick is dropped and the flag sticks.
    pix_ready = 1'b0;
    do_reset();
    cyc(700);
    chk("overrun_before", frame_overrun, 0);
    cyc(150);
    chk("overrun_after", frame_overrun, 1);
    cyc(500);
    chk("overrun_sticky", frame_overrun, 1);
    pix_ready = 1'b1;

    // Reset in the middle of a frame at cell (4,9).
    data_updated = rand144();
    do_reset();
    wait_cell(4, 9, 700);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("abort_valid", pix_valid, 0);
    wait_frames(1, 1000, "abort");
    chk("abort_first_valid", first_valid_rel, 400);
    chk("abort_finish", finish_rel, FIN0);

    // Random data and mostly-ready sink, then a slow sink that provokes overruns.
    do_reset();
    for (int i = 0; i < 2400; i++) begin
      data_updated = rand144();
      pix_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    chk("random_frames_seen", (frames >= 4) ? 1 : 0, 1);
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      data_updated = rand144();
      pix_ready = ($urandom_range(0, 4) == 0);
      cyc(1);
    end
    pix_ready = 1'b1;
    cyc(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
